// File: rtl/window_gen_5x5_pkg.sv
// Shared constants for the 5x5 sliding-window generator.
// Tap numbering: output S(WIN*r + c + 1) carries window register w[r][c],
// r = row (0 = oldest line), c = column (0 = oldest pixel). S1 is top-left,
// S25 is bottom-right (the pixel accepted most recently).
package window_gen_5x5_pkg;

  // Default pixel width in bits.
  localparam int unsigned PIX_W = 8;

  // Window edge length; the generator keeps WIN-1 line buffers.
  localparam int unsigned WIN = 5;

endpackage

// File: rtl/window_gen_5x5_line_buffer.sv
// One-line delay: circular RAM addressed by column, read-before-write.
// The old contents at addr appear on dout in the same cycle the new pixel
// is written, so a chain of these delays a stream by one line per stage.
module line_buffer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 640
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout
);

  // Storage is intentionally not reset; stale contents are masked upstream.
  logic [DATA_W-1:0] mem [DEPTH];

  // Old value at addr, read before the write on the same edge takes effect.
  assign dout = mem[addr];

  // Write the incoming pixel on every accepted beat.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
  end

endmodule

// File: rtl/window_gen_5x5.sv
// Raster-stream to 5x5 window converter. Emits only windows lying entirely
// inside the image, one done_o strobe per window, one cycle after the
// window's bottom-right pixel is accepted.
module window_gen_5x5
  import window_gen_5x5_pkg::*;
#(
  parameter int unsigned DATA_W     = PIX_W,
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_i,
  input  logic              done_i,
  output logic [DATA_W-1:0] S1,
  output logic [DATA_W-1:0] S2,
  output logic [DATA_W-1:0] S3,
  output logic [DATA_W-1:0] S4,
  output logic [DATA_W-1:0] S5,
  output logic [DATA_W-1:0] S6,
  output logic [DATA_W-1:0] S7,
  output logic [DATA_W-1:0] S8,
  output logic [DATA_W-1:0] S9,
  output logic [DATA_W-1:0] S10,
  output logic [DATA_W-1:0] S11,
  output logic [DATA_W-1:0] S12,
  output logic [DATA_W-1:0] S13,
  output logic [DATA_W-1:0] S14,
  output logic [DATA_W-1:0] S15,
  output logic [DATA_W-1:0] S16,
  output logic [DATA_W-1:0] S17,
  output logic [DATA_W-1:0] S18,
  output logic [DATA_W-1:0] S19,
  output logic [DATA_W-1:0] S20,
  output logic [DATA_W-1:0] S21,
  output logic [DATA_W-1:0] S22,
  output logic [DATA_W-1:0] S23,
  output logic [DATA_W-1:0] S24,
  output logic [DATA_W-1:0] S25,
  output logic              done_o,
  output logic              frame_done_o
);

  localparam int unsigned COL_W = $clog2(IMG_WIDTH);
  localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(WIN - 1);
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(WIN - 1);

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [DATA_W-1:0] lb_din  [WIN-1];
  logic [DATA_W-1:0] lb_out  [WIN-1];
  logic [DATA_W-1:0] new_col [WIN];
  logic [DATA_W-1:0] win     [WIN][WIN];
  logic              win_ok;
  logic              last_px;

  // Line-buffer chain: data_i -> LB0 -> LB1 -> LB2 -> LB3.
  assign lb_din[0] = data_i;

  for (genvar i = 0; i < WIN - 1; i++) begin : g_lb
    if (i > 0) begin : g_link
      assign lb_din[i] = lb_out[i-1];
    end
    line_buffer #(
      .DATA_W (DATA_W),
      .DEPTH  (IMG_WIDTH)
    ) u_lb (
      .clk  (clk),
      .we   (done_i),
      .addr (col),
      .din  (lb_din[i]),
      .dout (lb_out[i])
    );
  end

  // Incoming window column: bottom row is the live pixel, LBk feeds row 3-k.
  always_comb begin
    for (int unsigned r = 0; r < WIN; r++) begin
      new_col[r] = '0;
    end
    new_col[WIN-1] = data_i;
    for (int unsigned i = 0; i < WIN - 1; i++) begin
      new_col[WIN-2-i] = lb_out[i];
    end
  end

  // Window fully inside the image, and final pixel of the frame.
  assign win_ok  = (row >= ROW_FIRST) && (col >= COL_FIRST);
  assign last_px = (row == ROW_LAST) && (col == COL_LAST);

  // Raster position of the pixel accepted this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (done_i) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // 5x5 window: shift every row left, new column enters on the right.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < WIN; r++) begin
        for (int unsigned c = 0; c < WIN; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (done_i) begin
      for (int unsigned r = 0; r < WIN; r++) begin
        for (int unsigned c = 0; c < WIN - 1; c++) begin
          win[r][c] <= win[r][c+1];
        end
        win[r][WIN-1] <= new_col[r];
      end
    end
  end

  // Output strobes, registered alongside the window update.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_o       <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      done_o       <= done_i && win_ok;
      frame_done_o <= done_i && last_px;
    end
  end

  assign S1  = win[0][0];
  assign S2  = win[0][1];
  assign S3  = win[0][2];
  assign S4  = win[0][3];
  assign S5  = win[0][4];
  assign S6  = win[1][0];
  assign S7  = win[1][1];
  assign S8  = win[1][2];
  assign S9  = win[1][3];
  assign S10 = win[1][4];
  assign S11 = win[2][0];
  assign S12 = win[2][1];
  assign S13 = win[2][2];
  assign S14 = win[2][3];
  assign S15 = win[2][4];
  assign S16 = win[3][0];
  assign S17 = win[3][1];
  assign S18 = win[3][2];
  assign S19 = win[3][3];
  assign S20 = win[3][4];
  assign S21 = win[4][0];
  assign S22 = win[4][1];
  assign S23 = win[4][2];
  assign S24 = win[4][3];
  assign S25 = win[4][4];

endmodule

// File: tb/tb_window_gen_5x5.sv
// Directed bench for window_gen_5x5 on an 8x6 image.
module tb_window_gen_5x5;

  localparam int W = 8;
  localparam int H = 6;
  localparam int NPIX = W * H;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_i = '0;
  logic       done_i = 1'b0;
  logic [7:0] S1, S2, S3, S4, S5, S6, S7, S8, S9, S10, S11, S12, S13;
  logic [7:0] S14, S15, S16, S17, S18, S19, S20, S21, S22, S23, S24, S25;
  logic       done_o, frame_done_o;
  logic [199:0] taps;

  int n_checks = 0;
  int n_pass   = 0;

  // Per-cycle record of the most recent frame drive.
  logic [199:0] rec_taps [256];
  logic         rec_done [256];
  logic         rec_fd   [256];
  logic         rec_bub  [256];
  int           rec_lin  [256];
  int           n_rec;

  always #5 clk = ~clk;

  window_gen_5x5 #(
    .DATA_W     (8),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk (clk), .rst (rst), .data_i (data_i), .done_i (done_i),
    .S1 (S1), .S2 (S2), .S3 (S3), .S4 (S4), .S5 (S5),
    .S6 (S6), .S7 (S7), .S8 (S8), .S9 (S9), .S10 (S10),
    .S11 (S11), .S12 (S12), .S13 (S13), .S14 (S14), .S15 (S15),
    .S16 (S16), .S17 (S17), .S18 (S18), .S19 (S19), .S20 (S20),
    .S21 (S21), .S22 (S22), .S23 (S23), .S24 (S24), .S25 (S25),
    .done_o (done_o), .frame_done_o (frame_done_o)
  );

  assign taps = {S1, S2, S3, S4, S5, S6, S7, S8, S9, S10, S11, S12, S13,
                 S14, S15, S16, S17, S18, S19, S20, S21, S22, S23, S24, S25};

  // Ramp model: pixel value equals its linear raster index plus offset, so
  // tap (r,c) after accepting index lin is lin - (4-r)*W - (4-c) + off.
  function automatic logic [199:0] exp_taps(input int lin, input int off);
    logic [199:0] v;
    v = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        v[(24 - (5*r + c))*8 +: 8] = 8'(lin - (4-r)*W - (4-c) + off);
      end
    end
    return v;
  endfunction

  function automatic logic exp_done(input int lin);
    return ((lin / W) >= 4) && ((lin % W) >= 4);
  endfunction

  // One clock: drive at the falling edge, sample 1 ns after the rising edge.
  task automatic step(input logic v, input logic [7:0] d);
    @(negedge clk);
    done_i = v;
    data_i = d;
    @(posedge clk);
    #1;
  endtask

  // Drive one full frame; optional bubble on every third cycle.
  task automatic drive_frame(input int off, input bit gaps, input bit cnst);
    int p;
    int cyc;
    int lin;
    p = 0; cyc = 0; lin = -1; n_rec = 0;
    while (p < NPIX) begin
      if (gaps && (cyc % 3 == 2)) begin
        step(1'b0, 8'hEE);
        rec_bub[n_rec] = 1'b1;
      end else begin
        step(1'b1, cnst ? 8'd200 : 8'(p + off));
        lin = p;
        p++;
        rec_bub[n_rec] = 1'b0;
      end
      rec_lin[n_rec]  = lin;
      rec_done[n_rec] = done_o;
      rec_fd[n_rec]   = frame_done_o;
      rec_taps[n_rec] = taps;
      n_rec++;
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 8'd55);
    n_checks++;
    if (done_o !== 1'b0) $display("FAIL reset_done_o got=%b exp=0", done_o);
    else n_pass++;
    n_checks++;
    if (frame_done_o !== 1'b0) $display("FAIL reset_frame_done got=%b exp=0", frame_done_o);
    else n_pass++;
    n_checks++;
    if (taps !== 200'd0) $display("FAIL reset_taps got=%h exp=0", taps);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    done_i = 1'b0;
  endtask

  task automatic test_ramp();
    int first;
    int last;
    int nwin;
    int nfd;
    drive_frame(0, 1'b0, 1'b0);
    first = -1; last = -1; nwin = 0; nfd = 0;
    for (int k = 0; k < n_rec; k++) begin
      n_checks++;
      if (rec_done[k] !== exp_done(rec_lin[k]))
        $display("FAIL ramp_done_at_%0d got=%b exp=%b", k, rec_done[k], exp_done(rec_lin[k]));
      else n_pass++;
      if (rec_fd[k] === 1'b1) nfd++;
      if (rec_done[k] === 1'b1) begin
        if (first < 0) first = k;
        last = k;
        nwin++;
        n_checks++;
        if (rec_taps[k] !== exp_taps(rec_lin[k], 0))
          $display("FAIL ramp_window_%0d got=%h exp=%h", k, rec_taps[k], exp_taps(rec_lin[k], 0));
        else n_pass++;
      end
    end
    n_checks++;
    if (first !== 36) $display("FAIL ramp_first_idx got=%0d exp=36", first);
    else n_pass++;
    if (first >= 0) begin
      n_checks++;
      if (rec_taps[first][199:192] !== 8'd0 || rec_taps[first][103:96] !== 8'd18 ||
          rec_taps[first][7:0] !== 8'd36)
        $display("FAIL ramp_first_S1_S13_S25 got=%0d/%0d/%0d exp=0/18/36",
                 rec_taps[first][199:192], rec_taps[first][103:96], rec_taps[first][7:0]);
      else n_pass++;
    end
    n_checks++;
    if (nwin !== 8) $display("FAIL ramp_window_count got=%0d exp=8", nwin);
    else n_pass++;
    if (last >= 0) begin
      // Last window sits at (5,7): S1 = pixel(1,3) = 11, S25 = pixel(5,7) = 47.
      n_checks++;
      if (rec_taps[last][199:192] !== 8'd11 || rec_taps[last][7:0] !== 8'd47)
        $display("FAIL ramp_last_S1_S25 got=%0d/%0d exp=11/47",
                 rec_taps[last][199:192], rec_taps[last][7:0]);
      else n_pass++;
      n_checks++;
      if (rec_fd[last] !== 1'b1) $display("FAIL ramp_frame_done_last got=%b exp=1", rec_fd[last]);
      else n_pass++;
    end
    n_checks++;
    if (nfd !== 1) $display("FAIL ramp_frame_done_count got=%0d exp=1", nfd);
    else n_pass++;
  endtask

  task automatic test_bubbles();
    int nwin;
    logic ed;
    logic ef;
    drive_frame(0, 1'b1, 1'b0);
    nwin = 0;
    for (int k = 0; k < n_rec; k++) begin
      ed = rec_bub[k] ? 1'b0 : exp_done(rec_lin[k]);
      ef = rec_bub[k] ? 1'b0 : (rec_lin[k] == NPIX - 1);
      n_checks++;
      if (rec_done[k] !== ed) $display("FAIL bubble_done_at_%0d got=%b exp=%b", k, rec_done[k], ed);
      else n_pass++;
      n_checks++;
      if (rec_fd[k] !== ef) $display("FAIL bubble_frame_done_at_%0d got=%b exp=%b", k, rec_fd[k], ef);
      else n_pass++;
      if (rec_done[k] === 1'b1) nwin++;
      if ((rec_done[k] === 1'b1 || rec_bub[k]) && rec_lin[k] >= 36) begin
        n_checks++;
        if (rec_taps[k] !== exp_taps(rec_lin[k], 0))
          $display("FAIL bubble_taps_at_%0d got=%h exp=%h", k, rec_taps[k], exp_taps(rec_lin[k], 0));
        else n_pass++;
      end
    end
    n_checks++;
    if (nwin !== 8) $display("FAIL bubble_window_count got=%0d exp=8", nwin);
    else n_pass++;
  endtask

  task automatic test_constant();
    int nwin;
    drive_frame(0, 1'b0, 1'b1);
    nwin = 0;
    for (int k = 0; k < n_rec; k++) begin
      if (rec_done[k] === 1'b1) begin
        nwin++;
        n_checks++;
        if (rec_taps[k] !== {25{8'd200}})
          $display("FAIL const_window_%0d got=%h exp=all c8", k, rec_taps[k]);
        else n_pass++;
      end
    end
    n_checks++;
    if (nwin !== 8) $display("FAIL const_window_count got=%0d exp=8", nwin);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int first;
    int nwin;
    drive_frame(0, 1'b0, 1'b0);
    drive_frame(100, 1'b0, 1'b0);
    first = -1; nwin = 0;
    for (int k = 0; k < n_rec; k++) begin
      if (rec_done[k] === 1'b1) begin
        if (first < 0) first = k;
        nwin++;
        n_checks++;
        if (rec_taps[k] !== exp_taps(rec_lin[k], 100))
          $display("FAIL b2b_window_%0d got=%h exp=%h", k, rec_taps[k], exp_taps(rec_lin[k], 100));
        else n_pass++;
      end
    end
    n_checks++;
    if (first !== 36) $display("FAIL b2b_first_idx got=%0d exp=36", first);
    else n_pass++;
    if (first >= 0) begin
      n_checks++;
      if (rec_taps[first][199:192] !== 8'd100 || rec_taps[first][7:0] !== 8'd136)
        $display("FAIL b2b_first_S1_S25 got=%0d/%0d exp=100/136",
                 rec_taps[first][199:192], rec_taps[first][7:0]);
      else n_pass++;
    end
    n_checks++;
    if (nwin !== 8) $display("FAIL b2b_window_count got=%0d exp=8", nwin);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    int first;
    for (int p = 0; p < 40; p++) step(1'b1, 8'(p));
    // Pixel 39 sits at (4,7), so a window is being emitted right before reset.
    n_checks++;
    if (done_o !== 1'b1) $display("FAIL midrst_pre_done got=%b exp=1", done_o);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1; done_i = 1'b1; data_i = 8'd40;
    @(posedge clk);
    #1;
    n_checks++;
    if (done_o !== 1'b0) $display("FAIL midrst_done got=%b exp=0", done_o);
    else n_pass++;
    n_checks++;
    if (taps !== 200'd0) $display("FAIL midrst_taps got=%h exp=0", taps);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0; done_i = 1'b0;
    drive_frame(0, 1'b0, 1'b0);
    first = -1;
    for (int k = 0; k < n_rec; k++) begin
      if (first < 0 && rec_done[k] === 1'b1) first = k;
    end
    n_checks++;
    if (first !== 36) $display("FAIL midrst_first_idx got=%0d exp=36", first);
    else n_pass++;
    if (first >= 0) begin
      n_checks++;
      if (rec_taps[first][199:192] !== 8'd0 || rec_taps[first][7:0] !== 8'd36)
        $display("FAIL midrst_first_S1_S25 got=%0d/%0d exp=0/36",
                 rec_taps[first][199:192], rec_taps[first][7:0]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_bubbles();
    test_constant();
    test_back_to_back();
    test_mid_reset();
    step(1'b0, 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
